hex_pe_feeder: RTL and testbench

Source-side sequencer for the 16-lane Hex PE cluster. It reads packed IFM and weight vectors from the on-chip buffers and streams one 16-lane vector per cycle into the PE. It generates the PE's `pe_reset` and `pe_finish` controls, aligned to the PE's 4-stage adder-tree latency, so that each output pixel's dot product is accumulated and flagged valid. It sits between the IFM/weight SRAM read ports and the PE cluster inputs.

---
 rtl/hex_pe_feeder.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_hex_pe_feeder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_pe_feeder.sv
// ---------------------------------------------------------------------------
// hex_pe_feeder
//
// Source-side sequencer for the 16-lane Hex PE cluster. A job streams
// cfg_outputs output pixels of cfg_beats vectors each. One 16-lane IFM vector
// and one 16-lane weight vector go into the PE per cycle. The weight vectors
// are re-read for every output pixel. The block also generates pe_reset and
// pe_finish so that they line up with the PE adder-tree latency. The PE
// accumulator then starts and closes each dot product on the right beat.
//
// Parameters
//   ADDR_W  buffer address width (address arithmetic wraps modulo 2^ADDR_W)
//   CNT_W   width of the beat and output counters
//   PE_LAT  PE adder-tree register stages between lanes and accumulator
//
// Ports
//   clk, reset_n                   clock, asynchronous active-low reset
//   start                          single-cycle job start, ignored while busy
//   cfg_beats / cfg_outputs        K vectors per output, N outputs (latched on start)
//   cfg_ifm_base / cfg_wgt_base    buffer base addresses (latched on start)
//   ifm_rd_en/_addr/_data          IFM buffer read port (data 1 cycle after en)
//   wgt_rd_en/_addr/_data          weight buffer read port (data 1 cycle after en)
//   pe_ifm / pe_wgt                16 x 8-bit lanes; lane i at bits [8i+7:8i]
//   pe_reset / pe_finish           first / last beat of an output at the accumulator
//   busy                           job in progress (start+1 through the done cycle)
//   done                           single-cycle pulse at job end
//
// Build option
//   HEX_PE_FEEDER_ZERO_IDLE_EN  when defined, the lane registers are forced to
//                               zero on cycles without a valid beat. Otherwise
//                               they hold their last value.
//
// Timing (beat issued in cycle c)
//   c+1  read data returns, beat tag in marker stage 0
//   c+2  data on pe_ifm/pe_wgt
//   c+2+PE_LAT  tag at the end of the marker pipe -> pe_reset/pe_finish
//   done follows when the marker pipe is empty again: L+3+PE_LAT.
// ---------------------------------------------------------------------------
module hex_pe_feeder #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10,
    parameter int PE_LAT = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_beats,
    input  logic [CNT_W-1:0]  cfg_outputs,
    input  logic [ADDR_W-1:0] cfg_ifm_base,
    input  logic [ADDR_W-1:0] cfg_wgt_base,

    output logic              ifm_rd_en,
    output logic [ADDR_W-1:0] ifm_rd_addr,
    input  logic [127:0]      ifm_rd_data,

    output logic              wgt_rd_en,
    output logic [ADDR_W-1:0] wgt_rd_addr,
    input  logic [127:0]      wgt_rd_data,

    output logic [127:0]      pe_ifm,
    output logic [127:0]      pe_wgt,
    output logic              pe_reset,
    output logic              pe_finish,

    output logic              busy,
    output logic              done
);

    // Stage 0 lines up with returning read data. Stage 1 lines up with the
    // lane registers. The last stage lines up with the PE accumulator input.
    localparam int PIPE_D = 2 + PE_LAT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Per-beat tag that travels alongside the data toward the accumulator.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t            r_state;
    logic [CNT_W-1:0]  r_beats;       // latched K
    logic [CNT_W-1:0]  r_outputs;     // latched N
    logic [ADDR_W-1:0] r_wgt_base;    // weight pointer reload value per output
    logic [CNT_W-1:0]  r_beat;        // b: 0..K-1
    logic [CNT_W-1:0]  r_out;         // o: 0..N-1
    logic [ADDR_W-1:0] r_ifm_ptr;     // ifm_base + o*K + b, kept as a running sum
    logic [ADDR_W-1:0] r_wgt_ptr;     // wgt_base + b
    logic              r_zero_done;   // done pulse for an empty job
    tag_t              r_mark [PIPE_D];
    logic [127:0]      r_pe_ifm;
    logic [127:0]      r_pe_wgt;

    // -----------------------------------------------------------------------
    // Combinational signals
    // -----------------------------------------------------------------------
    state_t            w_next_state;
    logic              w_issue;       // a beat is issued this cycle
    logic              w_load;        // accept a non-empty job
    logic              w_zero_job;    // accept an empty job (K or N is zero)
    logic              w_drain_done;  // final done pulse of a real job
    logic              w_cfg_ok;
    logic              w_last_beat;
    logic              w_last_out;
    logic              w_pipe_empty;
    tag_t              w_issue_tag;

    assign w_cfg_ok    = (cfg_beats != '0) && (cfg_outputs != '0);
    assign w_last_beat = (r_beat == r_beats - CNT_W'(1));
    assign w_last_out  = (r_out == r_outputs - CNT_W'(1));

    always_comb begin
        w_pipe_empty = 1'b1;
        for (int i = 0; i < PIPE_D; i++) begin
            if (r_mark[i].valid) begin
                w_pipe_empty = 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and control strobes
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default before the case statement.
    // A path that does not assign a signal would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_load       = 1'b0;
        w_zero_job   = 1'b0;
        w_drain_done = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A start that coincides with the empty-job done pulse is
                // dropped. The done of a real job is raised in DRAIN, where
                // start is ignored anyway.
                if (start && !r_zero_done) begin
                    if (w_cfg_ok) begin
                        w_load       = 1'b1;
                        w_next_state = ST_ISSUE;
                    end else begin
                        w_zero_job = 1'b1;
                    end
                end
            end

            ST_ISSUE: begin
                w_issue = 1'b1;
                if (w_last_beat && w_last_out) begin
                    w_next_state = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // The final pe_finish left the pipe last cycle. The pipe is now
                // empty, which is the cycle in which the PE presents the result.
                if (w_pipe_empty) begin
                    w_drain_done = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Counters and address pointers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together from values sampled before the clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beats     <= '0;
            r_outputs   <= '0;
            r_wgt_base  <= '0;
            r_beat      <= '0;
            r_out       <= '0;
            r_ifm_ptr   <= '0;
            r_wgt_ptr   <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= w_zero_job;

            if (w_load) begin
                r_beats    <= cfg_beats;
                r_outputs  <= cfg_outputs;
                r_wgt_base <= cfg_wgt_base;
                r_ifm_ptr  <= cfg_ifm_base;
                r_wgt_ptr  <= cfg_wgt_base;
                r_beat     <= '0;
                r_out      <= '0;
            end else if (w_issue) begin
                // IFM vectors of consecutive outputs are contiguous, so the
                // pointer just keeps counting. This replaces o*K + b.
                r_ifm_ptr <= r_ifm_ptr + ADDR_W'(1);
                if (w_last_beat) begin
                    r_beat    <= '0;
                    r_out     <= r_out + CNT_W'(1);
                    r_wgt_ptr <= r_wgt_base;
                end else begin
                    r_beat    <= r_beat + CNT_W'(1);
                    r_wgt_ptr <= r_wgt_ptr + ADDR_W'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Beat marker pipe
    // -----------------------------------------------------------------------
    always_comb begin
        w_issue_tag       = '0;
        w_issue_tag.valid = w_issue;
        w_issue_tag.first = w_issue && (r_beat == '0);
        w_issue_tag.last  = w_issue && w_last_beat;
    end

    // NOTE: this shift register is reset, unlike a plain storage array. A reset
    // in the middle of a job must not leave stale tags that later fire
    // pe_reset/pe_finish or hold off done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_D; i++) begin
                r_mark[i] <= '0;
            end
        end else begin
            r_mark[0] <= w_issue_tag;
            for (int i = 1; i < PIPE_D; i++) begin
                r_mark[i] <= r_mark[i-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Lane registers: capture read data in the cycle it returns. This is the
    // same cycle in which the beat's tag sits in marker stage 0.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pe_ifm <= '0;
            r_pe_wgt <= '0;
        end else begin
`ifdef HEX_PE_FEEDER_ZERO_IDLE_EN
            // Zeros on idle lanes keep the PE OFM stable after the last
            // accumulation.
            if (r_mark[0].valid) begin
                r_pe_ifm <= ifm_rd_data;
                r_pe_wgt <= wgt_rd_data;
            end else begin
                r_pe_ifm <= '0;
                r_pe_wgt <= '0;
            end
`else
            // Holding the last value on idle cycles avoids needless lane
            // toggling.
            if (r_mark[0].valid) begin
                r_pe_ifm <= ifm_rd_data;
                r_pe_wgt <= wgt_rd_data;
            end
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign ifm_rd_en   = w_issue;
    assign wgt_rd_en   = w_issue;
    assign ifm_rd_addr = r_ifm_ptr;
    assign wgt_rd_addr = r_wgt_ptr;

    assign pe_ifm      = r_pe_ifm;
    assign pe_wgt      = r_pe_wgt;
    assign pe_reset    = r_mark[PIPE_D-1].valid && r_mark[PIPE_D-1].first;
    assign pe_finish   = r_mark[PIPE_D-1].valid && r_mark[PIPE_D-1].last;

    assign busy        = (r_state != ST_IDLE);
    assign done        = w_drain_done || r_zero_done;

endmodule

// File: tb/tb_hex_pe_feeder.sv
// ---------------------------------------------------------------------------
// tb_hex_pe_feeder
//
// Directed bench for hex_pe_feeder. It contains a registered-read SRAM model
// that returns address-derived data, or all-ones when ones_mode is set. It also
// contains a small PE model: a 4-stage dot-product pipe feeding an accumulator
// that is controlled by pe_reset/pe_finish. Each job is recorded cycle by cycle
// by capture(), with cycle 0 being the start cycle. Each test task then
// compares the record against hand-derived expectations.
// ---------------------------------------------------------------------------
module tb_hex_pe_feeder;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 10;
    localparam int PE_LAT = 4;
    localparam int LOG_N  = 64;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [CNT_W-1:0]  cfg_beats;
    logic [CNT_W-1:0]  cfg_outputs;
    logic [ADDR_W-1:0] cfg_ifm_base;
    logic [ADDR_W-1:0] cfg_wgt_base;
    logic              ifm_rd_en;
    logic [ADDR_W-1:0] ifm_rd_addr;
    logic [127:0]      ifm_rd_data;
    logic              wgt_rd_en;
    logic [ADDR_W-1:0] wgt_rd_addr;
    logic [127:0]      wgt_rd_data;
    logic [127:0]      pe_ifm;
    logic [127:0]      pe_wgt;
    logic              pe_reset;
    logic              pe_finish;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;
    bit ones_mode = 1'b0;

    hex_pe_feeder #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .PE_LAT (PE_LAT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .cfg_beats    (cfg_beats),
        .cfg_outputs  (cfg_outputs),
        .cfg_ifm_base (cfg_ifm_base),
        .cfg_wgt_base (cfg_wgt_base),
        .ifm_rd_en    (ifm_rd_en),
        .ifm_rd_addr  (ifm_rd_addr),
        .ifm_rd_data  (ifm_rd_data),
        .wgt_rd_en    (wgt_rd_en),
        .wgt_rd_addr  (wgt_rd_addr),
        .wgt_rd_data  (wgt_rd_data),
        .pe_ifm       (pe_ifm),
        .pe_wgt       (pe_wgt),
        .pe_reset     (pe_reset),
        .pe_finish    (pe_finish),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- data patterns and PE arithmetic ----------------
    function automatic logic [127:0] ifm_word(input logic [9:0] a);
        logic [127:0] w;
        for (int i = 0; i < 16; i++) w[8*i +: 8] = a[7:0] + 8'(i);
        return w;
    endfunction

    function automatic logic [127:0] wgt_word(input logic [9:0] a);
        logic [127:0] w;
        for (int i = 0; i < 16; i++) w[8*i +: 8] = (a[7:0] ^ 8'h5A) + 8'(i);
        return w;
    endfunction

    function automatic logic [31:0] dot(input logic [127:0] a, input logic [127:0] b);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < 16; i++) s = s + 32'(a[8*i +: 8]) * 32'(b[8*i +: 8]);
        return s;
    endfunction

    // ---------------- SRAM models (1-cycle read latency) ----------------
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ifm_rd_data <= '0;
            wgt_rd_data <= '0;
        end else begin
            if (ifm_rd_en) ifm_rd_data <= ones_mode ? {16{8'h01}} : ifm_word(ifm_rd_addr);
            if (wgt_rd_en) wgt_rd_data <= ones_mode ? {16{8'h01}} : wgt_word(wgt_rd_addr);
        end
    end

    // ---------------- PE model: 4-stage tree + accumulator ----------------
    logic [31:0] t0, t1, t2, t3, acc, ofm;
    logic        ofm_valid;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t0 <= '0; t1 <= '0; t2 <= '0; t3 <= '0;
            acc <= '0; ofm <= '0; ofm_valid <= 1'b0;
        end else begin
            t0 <= dot(pe_ifm, pe_wgt);
            t1 <= t0;
            t2 <= t1;
            t3 <= t2;
            acc <= pe_reset ? t3 : acc + t3;
            ofm_valid <= pe_finish;
            if (pe_finish) ofm <= pe_reset ? t3 : acc + t3;
        end
    end

    // ---------------- per-cycle record ----------------
    logic              lg_ird  [LOG_N];
    logic              lg_wrd  [LOG_N];
    logic [ADDR_W-1:0] lg_ia   [LOG_N];
    logic [ADDR_W-1:0] lg_wa   [LOG_N];
    logic              lg_rst  [LOG_N];
    logic              lg_fin  [LOG_N];
    logic              lg_busy [LOG_N];
    logic              lg_done [LOG_N];
    logic              lg_ov   [LOG_N];
    logic [31:0]       lg_ofm  [LOG_N];
    logic [127:0]      lg_pi   [LOG_N];
    logic [127:0]      lg_pw   [LOG_N];

    // Pulse start in cycle 0 and record ncyc cycles. If restart is set, a
    // second start with a non-empty config is raised in cycle 1.
    task automatic capture(input int k, input int n, input logic [9:0] ib,
                           input logic [9:0] wb, input int ncyc, input bit restart);
        @(posedge clk); #1;
        cfg_beats    = CNT_W'(k);
        cfg_outputs  = CNT_W'(n);
        cfg_ifm_base = ib;
        cfg_wgt_base = wb;
        for (int c = 0; c < ncyc; c++) begin
            if (c == 1 && restart) begin
                cfg_beats   = CNT_W'(2);
                cfg_outputs = CNT_W'(2);
            end
            start = (c == 0) || (c == 1 && restart);
            @(negedge clk);
            lg_ird[c]  = ifm_rd_en;   lg_wrd[c] = wgt_rd_en;
            lg_ia[c]   = ifm_rd_addr; lg_wa[c]  = wgt_rd_addr;
            lg_rst[c]  = pe_reset;    lg_fin[c] = pe_finish;
            lg_busy[c] = busy;        lg_done[c] = done;
            lg_ov[c]   = ofm_valid;   lg_ofm[c] = ofm;
            lg_pi[c]   = pe_ifm;      lg_pw[c]  = pe_wgt;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [5:0] ctl;
        int active;
        reset_n = 1'b1; start = 1'b0;
        cfg_beats = '0; cfg_outputs = '0; cfg_ifm_base = '0; cfg_wgt_base = '0;
        #2 reset_n = 1'b0;
        #1;
        ctl = {ifm_rd_en, wgt_rd_en, pe_reset, pe_finish, busy, done};
        total++; if (ctl !== 6'b0) begin bad++; $display("FAIL reset_ctl: got %b expected 000000", ctl); end
        total++; if (ifm_rd_addr !== '0) begin bad++; $display("FAIL reset_ifm_addr: got %h expected 000", ifm_rd_addr); end
        total++; if (wgt_rd_addr !== '0) begin bad++; $display("FAIL reset_wgt_addr: got %h expected 000", wgt_rd_addr); end
        total++; if (pe_ifm !== '0) begin bad++; $display("FAIL reset_pe_ifm: got %h expected 0", pe_ifm); end
        total++; if (pe_wgt !== '0) begin bad++; $display("FAIL reset_pe_wgt: got %h expected 0", pe_wgt); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        active = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if ({ifm_rd_en, wgt_rd_en, pe_reset, pe_finish, busy, done} != 6'b0 ||
                pe_ifm != '0 || pe_wgt != '0 || ifm_rd_addr != '0 || wgt_rd_addr != '0) active++;
        end
        total++; if (active !== 0) begin bad++; $display("FAIL post_reset_quiet: got %0d active cycles expected 0", active); end
    endtask

    task automatic test_k1_single();
        ones_mode = 1'b0;
        capture(1, 1, 10'h010, 10'h200, 12, 1'b0);
        for (int c = 0; c < 12; c++) begin
            total++; if (lg_ird[c] !== (c == 1)) begin bad++; $display("FAIL k1_ifm_rd_en c%0d: got %b expected %b", c, lg_ird[c], (c == 1)); end
            total++; if (lg_wrd[c] !== (c == 1)) begin bad++; $display("FAIL k1_wgt_rd_en c%0d: got %b expected %b", c, lg_wrd[c], (c == 1)); end
            total++; if (lg_rst[c] !== (c == 7)) begin bad++; $display("FAIL k1_pe_reset c%0d: got %b expected %b", c, lg_rst[c], (c == 7)); end
            total++; if (lg_fin[c] !== (c == 7)) begin bad++; $display("FAIL k1_pe_finish c%0d: got %b expected %b", c, lg_fin[c], (c == 7)); end
            total++; if (lg_done[c] !== (c == 8)) begin bad++; $display("FAIL k1_done c%0d: got %b expected %b", c, lg_done[c], (c == 8)); end
            total++; if (lg_busy[c] !== (c >= 1 && c <= 8)) begin bad++; $display("FAIL k1_busy c%0d: got %b expected %b", c, lg_busy[c], (c >= 1 && c <= 8)); end
        end
        total++; if (lg_ia[1] !== 10'h010) begin bad++; $display("FAIL k1_ifm_addr: got %h expected 010", lg_ia[1]); end
        total++; if (lg_wa[1] !== 10'h200) begin bad++; $display("FAIL k1_wgt_addr: got %h expected 200", lg_wa[1]); end
        total++; if (lg_pi[3] !== ifm_word(10'h010)) begin bad++; $display("FAIL k1_pe_ifm c3: got %h expected %h", lg_pi[3], ifm_word(10'h010)); end
        total++; if (lg_pw[3] !== wgt_word(10'h200)) begin bad++; $display("FAIL k1_pe_wgt c3: got %h expected %h", lg_pw[3], wgt_word(10'h200)); end
`ifdef HEX_PE_FEEDER_ZERO_IDLE_EN
        total++; if (lg_pi[4] !== '0) begin bad++; $display("FAIL k1_pe_ifm_idle c4: got %h expected 0", lg_pi[4]); end
`else
        total++; if (lg_pi[4] !== ifm_word(10'h010)) begin bad++; $display("FAIL k1_pe_ifm_hold c4: got %h expected %h", lg_pi[4], ifm_word(10'h010)); end
`endif
        total++; if (lg_ov[8] !== 1'b1) begin bad++; $display("FAIL k1_ofm_valid c8: got %b expected 1", lg_ov[8]); end
        total++; if (lg_ofm[8] !== dot(ifm_word(10'h010), wgt_word(10'h200))) begin bad++; $display("FAIL k1_ofm c8: got %0d expected %0d", lg_ofm[8], dot(ifm_word(10'h010), wgt_word(10'h200))); end
    endtask

    task automatic test_k4_n3_ones();
        bit e;
        ones_mode = 1'b1;
        capture(4, 3, 10'h000, 10'h000, 22, 1'b0);
        for (int c = 0; c < 22; c++) begin
            e = (c >= 1 && c <= 12);
            total++; if (lg_ird[c] !== e) begin bad++; $display("FAIL k4_rd_en c%0d: got %b expected %b", c, lg_ird[c], e); end
            e = (c == 7 || c == 11 || c == 15);
            total++; if (lg_rst[c] !== e) begin bad++; $display("FAIL k4_pe_reset c%0d: got %b expected %b", c, lg_rst[c], e); end
            e = (c == 10 || c == 14 || c == 18);
            total++; if (lg_fin[c] !== e) begin bad++; $display("FAIL k4_pe_finish c%0d: got %b expected %b", c, lg_fin[c], e); end
            e = (c == 11 || c == 15 || c == 19);
            total++; if (lg_ov[c] !== e) begin bad++; $display("FAIL k4_ofm_valid c%0d: got %b expected %b", c, lg_ov[c], e); end
            if (e) begin
                total++; if (lg_ofm[c] !== 32'd64) begin bad++; $display("FAIL k4_ofm c%0d: got %0d expected 64", c, lg_ofm[c]); end
            end
            total++; if (lg_done[c] !== (c == 19)) begin bad++; $display("FAIL k4_done c%0d: got %b expected %b", c, lg_done[c], (c == 19)); end
            total++; if (lg_busy[c] !== (c >= 1 && c <= 19)) begin bad++; $display("FAIL k4_busy c%0d: got %b expected %b", c, lg_busy[c], (c >= 1 && c <= 19)); end
        end
        for (int c = 1; c <= 12; c++) begin
            total++; if (lg_ia[c] !== 10'(c - 1)) begin bad++; $display("FAIL k4_ifm_addr c%0d: got %h expected %h", c, lg_ia[c], 10'(c - 1)); end
            total++; if (lg_wa[c] !== 10'((c - 1) % 4)) begin bad++; $display("FAIL k4_wgt_addr c%0d: got %h expected %h", c, lg_wa[c], 10'((c - 1) % 4)); end
        end
        ones_mode = 1'b0;
    endtask

    task automatic test_zero_cfg();
        // K=0, plus a second start raised in the done cycle, which must be dropped.
        capture(0, 3, 10'h055, 10'h066, 8, 1'b1);
        for (int c = 0; c < 8; c++) begin
            total++; if (lg_ird[c] !== 1'b0) begin bad++; $display("FAIL zk_rd_en c%0d: got %b expected 0", c, lg_ird[c]); end
            total++; if (lg_busy[c] !== 1'b0) begin bad++; $display("FAIL zk_busy c%0d: got %b expected 0", c, lg_busy[c]); end
            total++; if (lg_done[c] !== (c == 1)) begin bad++; $display("FAIL zk_done c%0d: got %b expected %b", c, lg_done[c], (c == 1)); end
        end
        // N=0
        capture(5, 0, 10'h011, 10'h022, 4, 1'b0);
        for (int c = 0; c < 4; c++) begin
            total++; if (lg_ird[c] !== 1'b0) begin bad++; $display("FAIL zn_rd_en c%0d: got %b expected 0", c, lg_ird[c]); end
            total++; if (lg_done[c] !== (c == 1)) begin bad++; $display("FAIL zn_done c%0d: got %b expected %b", c, lg_done[c], (c == 1)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] ctl;
        int seen_fin, seen_done, seen_act;
        bit e;
        @(posedge clk); #1;
        cfg_beats = 10'd8; cfg_outputs = 10'd4; cfg_ifm_base = 10'h100; cfg_wgt_base = 10'h080;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        reset_n = 1'b0;
        #1;
        ctl = {ifm_rd_en, wgt_rd_en, pe_reset, pe_finish, busy, done};
        total++; if (ctl !== 6'b0) begin bad++; $display("FAIL mid_reset_ctl: got %b expected 000000", ctl); end
        total++; if (ifm_rd_addr !== '0 || wgt_rd_addr !== '0) begin bad++; $display("FAIL mid_reset_addr: got %h/%h expected 000/000", ifm_rd_addr, wgt_rd_addr); end
        total++; if (pe_ifm !== '0 || pe_wgt !== '0) begin bad++; $display("FAIL mid_reset_lanes: got %h/%h expected 0/0", pe_ifm, pe_wgt); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        seen_fin = 0; seen_done = 0; seen_act = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (pe_finish) seen_fin++;
            if (done) seen_done++;
            if (busy || ifm_rd_en || pe_reset) seen_act++;
        end
        total++; if (seen_fin !== 0) begin bad++; $display("FAIL mid_no_finish: got %0d expected 0", seen_fin); end
        total++; if (seen_done !== 0) begin bad++; $display("FAIL mid_no_done: got %0d expected 0", seen_done); end
        total++; if (seen_act !== 0) begin bad++; $display("FAIL mid_no_activity: got %0d expected 0", seen_act); end

        // Full job after the abort.
        capture(8, 4, 10'h100, 10'h080, 42, 1'b0);
        for (int c = 0; c < 42; c++) begin
            total++; if (lg_ird[c] !== (c >= 1 && c <= 32)) begin bad++; $display("FAIL re_rd_en c%0d: got %b expected %b", c, lg_ird[c], (c >= 1 && c <= 32)); end
            e = (c >= 7 && c <= 31 && (c - 7) % 8 == 0);
            total++; if (lg_rst[c] !== e) begin bad++; $display("FAIL re_pe_reset c%0d: got %b expected %b", c, lg_rst[c], e); end
            e = (c >= 14 && c <= 38 && (c - 14) % 8 == 0);
            total++; if (lg_fin[c] !== e) begin bad++; $display("FAIL re_pe_finish c%0d: got %b expected %b", c, lg_fin[c], e); end
            total++; if (lg_done[c] !== (c == 39)) begin bad++; $display("FAIL re_done c%0d: got %b expected %b", c, lg_done[c], (c == 39)); end
            total++; if (lg_busy[c] !== (c >= 1 && c <= 39)) begin bad++; $display("FAIL re_busy c%0d: got %b expected %b", c, lg_busy[c], (c >= 1 && c <= 39)); end
            if (c >= 1 && c <= 32) begin
                total++; if (lg_ia[c] !== 10'(10'h100 + c - 1)) begin bad++; $display("FAIL re_ifm_addr c%0d: got %h expected %h", c, lg_ia[c], 10'(10'h100 + c - 1)); end
                total++; if (lg_wa[c] !== 10'(10'h080 + (c - 1) % 8)) begin bad++; $display("FAIL re_wgt_addr c%0d: got %h expected %h", c, lg_wa[c], 10'(10'h080 + (c - 1) % 8)); end
            end
            if (c >= 3 && c <= 34) begin
                total++; if (lg_pi[c] !== ifm_word(10'(10'h100 + c - 3))) begin bad++; $display("FAIL re_pe_ifm c%0d: got %h expected %h", c, lg_pi[c], ifm_word(10'(10'h100 + c - 3))); end
                total++; if (lg_pw[c] !== wgt_word(10'(10'h080 + (c - 3) % 8))) begin bad++; $display("FAIL re_pe_wgt c%0d: got %h expected %h", c, lg_pw[c], wgt_word(10'(10'h080 + (c - 3) % 8))); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [9:0] exp_i [4];
        logic [9:0] exp_w [4];
        exp_i = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        exp_w = '{10'h3FD, 10'h3FE, 10'h3FF, 10'h000};
        capture(4, 1, 10'h3FE, 10'h3FD, 12, 1'b0);
        for (int j = 0; j < 4; j++) begin
            total++; if (lg_ia[j + 1] !== exp_i[j]) begin bad++; $display("FAIL wrap_ifm_addr c%0d: got %h expected %h", j + 1, lg_ia[j + 1], exp_i[j]); end
            total++; if (lg_wa[j + 1] !== exp_w[j]) begin bad++; $display("FAIL wrap_wgt_addr c%0d: got %h expected %h", j + 1, lg_wa[j + 1], exp_w[j]); end
            total++; if (lg_pi[j + 3] !== ifm_word(exp_i[j])) begin bad++; $display("FAIL wrap_pe_ifm c%0d: got %h expected %h", j + 3, lg_pi[j + 3], ifm_word(exp_i[j])); end
        end
        total++; if (lg_rst[7] !== 1'b1 || lg_fin[10] !== 1'b1) begin bad++; $display("FAIL wrap_markers: got reset@7=%b finish@10=%b expected 1/1", lg_rst[7], lg_fin[10]); end
        total++; if (lg_done[11] !== 1'b1 || lg_done[10] !== 1'b0) begin bad++; $display("FAIL wrap_done: got c10=%b c11=%b expected 0/1", lg_done[10], lg_done[11]); end
`ifdef HEX_PE_FEEDER_ZERO_IDLE_EN
        total++; if (lg_pi[7] !== '0 || lg_pw[7] !== '0) begin bad++; $display("FAIL wrap_idle_zero c7: got %h/%h expected 0/0", lg_pi[7], lg_pw[7]); end
`else
        total++; if (lg_pi[7] !== ifm_word(10'h001)) begin bad++; $display("FAIL wrap_idle_hold c7: got %h expected %h", lg_pi[7], ifm_word(10'h001)); end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_k1_single();
        test_k4_n3_ones();
        test_zero_cfg();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
